generic_bus_arbiter: RTL

//  Shares one generic_bus slave port (memory/L2 side) between two generic_bus

---
 rtl/generic_bus_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/generic_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : generic_bus_arbiter
//  Description : Two-master (fetch / data) arbiter onto one generic_bus slave
//                port, data priority with a bounded fetch-starvation streak.
//  Revision    : 1.0 - initial release
// ============================================================================
module generic_bus_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                i_ren,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_busy,
    output logic                i_error,
    input  logic                d_ren,
    input  logic                d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_byte_en,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_busy,
    output logic                d_error,
    output logic                m_ren,
    output logic                m_wen,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_byte_en,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_busy,
    input  logic                m_error
);

    localparam int              BE_W       = DATA_W / 8;
    localparam int              SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [SW-1:0]   STREAK_ONE = SW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_XFER = 2'd1,
        D_XFER = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SW-1:0]       d_streak;
    logic [SW-1:0]       d_streak_nxt;
    logic                grant_d;
    logic                grant_i;

    logic                lat_ren;
    logic                lat_wen;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [BE_W-1:0]     lat_be;

    always_comb begin
        state_nxt    = state;
        d_streak_nxt = d_streak;
        grant_d      = 1'b0;
        grant_i      = 1'b0;
        m_ren        = 1'b0;
        m_wen        = 1'b0;
        m_addr       = '0;
        m_wdata      = '0;
        m_byte_en    = '0;
        i_busy       = 1'b1;
        i_rdata      = '0;
        i_error      = 1'b0;
        d_busy       = 1'b1;
        d_rdata      = '0;
        d_error      = 1'b0;

        case (state)
            IDLE: begin
                // Data wins unless fetch has been passed over MAX_D_STREAK times
                grant_d = (d_ren || d_wen) && (!i_ren || (d_streak != STREAK_MAX));
                grant_i = i_ren && !grant_d;
                if (grant_d) begin
                    state_nxt = D_XFER;
                end else if (grant_i) begin
                    state_nxt = I_XFER;
                end
                if (grant_i || !i_ren) begin
                    d_streak_nxt = '0;
                end else if (grant_d && (d_streak != STREAK_MAX)) begin
                    d_streak_nxt = d_streak + STREAK_ONE;
                end
            end
            I_XFER, D_XFER: begin
                m_ren     = lat_ren;
                m_wen     = lat_wen;
                m_addr    = lat_addr;
                m_wdata   = lat_wdata;
                m_byte_en = lat_be;
                if (!m_busy) begin
                    state_nxt = IDLE;
                    if (state == I_XFER) begin
                        i_busy  = 1'b0;
                        i_rdata = m_rdata;
                        i_error = m_error;
                    end else begin
                        d_busy  = 1'b0;
                        d_rdata = m_rdata;
                        d_error = m_error;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            d_streak  <= '0;
            lat_ren   <= 1'b0;
            lat_wen   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            state    <= state_nxt;
            d_streak <= d_streak_nxt;
            if (grant_d) begin
                lat_ren   <= d_ren;
                lat_wen   <= d_wen;
                lat_addr  <= d_addr;
                lat_wdata <= d_wdata;
                lat_be    <= d_byte_en;
            end else if (grant_i) begin
                // Fetch is always a full-width read
                lat_ren   <= 1'b1;
                lat_wen   <= 1'b0;
                lat_addr  <= i_addr;
                lat_wdata <= '0;
                lat_be    <= '1;
            end
        end
    end

endmodule
`default_nettype wire
